// File: rtl/cfg_store_pkg.sv
// Shared defaults, entry shape and controller state for the keyed list store.
package cfg_store_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int KEY_W_DEF       = 16;
  localparam int NUM_ENTRIES_DEF = 16;
  localparam int LIST_DEPTH_DEF  = 8;
  localparam int CNT_W_DEF       = $clog2(LIST_DEPTH_DEF) + 1;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [KEY_W_DEF-1:0] key;
    logic [CNT_W_DEF-1:0] count;
  } entry_t;

endpackage

// File: rtl/cfg_store_if.sv
// Write, lookup/response and clear/status signals of the config store.
interface cfg_store_if import cfg_store_pkg::*; #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int KEY_W       = KEY_W_DEF,
  parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
  parameter int LIST_DEPTH  = LIST_DEPTH_DEF
);
  localparam int IDX_W  = $clog2(LIST_DEPTH) + 1;
  localparam int USED_W = $clog2(NUM_ENTRIES) + 1;

  logic              wr_valid;
  logic              wr_ready;
  logic [KEY_W-1:0]  wr_key;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              wr_err;
  logic              rd_valid;
  logic              rd_ready;
  logic [KEY_W-1:0]  rd_key;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_def;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_hit;
  logic [IDX_W-1:0]  rsp_count;
  logic              clr_req;
  logic              clr_busy;
  logic [USED_W-1:0] used_cnt;

  modport master (
    output wr_valid, wr_key, wr_idx, wr_data, rd_valid, rd_key, rd_idx, rd_def,
           rsp_ready, clr_req,
    input  wr_ready, wr_err, rd_ready, rsp_valid, rsp_data, rsp_hit, rsp_count,
           clr_busy, used_cnt
  );

  modport slave (
    input  wr_valid, wr_key, wr_idx, wr_data, rd_valid, rd_key, rd_idx, rd_def,
           rsp_ready, clr_req,
    output wr_ready, wr_err, rd_ready, rsp_valid, rsp_data, rsp_hit, rsp_count,
           clr_busy, used_cnt
  );
endinterface

// File: rtl/cfg_store_match.sv
// Combinational key search: per-entry match vectors for the write and lookup
// keys, their encoded entry index, and the lowest free entry.
module cfg_store_match import cfg_store_pkg::*; #(
  parameter int KEY_W       = KEY_W_DEF,
  parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
  parameter int ENT_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic [NUM_ENTRIES-1:0] valid,
  input  logic [KEY_W-1:0]       keys [NUM_ENTRIES],
  input  logic [KEY_W-1:0]       wr_key,
  input  logic [KEY_W-1:0]       rd_key,
  output logic [NUM_ENTRIES-1:0] wr_match,
  output logic [ENT_W-1:0]       wr_ent,
  output logic [NUM_ENTRIES-1:0] rd_match,
  output logic [ENT_W-1:0]       rd_ent,
  output logic                   free_any,
  output logic [ENT_W-1:0]       free_ent
);

  // Keys are unique among valid entries, so OR-encoding the match is exact.
  always_comb begin
    wr_match = '0;
    rd_match = '0;
    wr_ent   = '0;
    rd_ent   = '0;
    free_any = 1'b0;
    free_ent = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      wr_match[i] = valid[i] && (keys[i] == wr_key);
      rd_match[i] = valid[i] && (keys[i] == rd_key);
      if (wr_match[i]) wr_ent = wr_ent | ENT_W'(i);
      if (rd_match[i]) rd_ent = rd_ent | ENT_W'(i);
      if (!valid[i] && !free_any) begin
        free_any = 1'b1;
        free_ent = ENT_W'(i);
      end
    end
  end

endmodule

// File: rtl/cfg_store.sv
// Keyed table of short value lists with registered lookups and a sequential
// one-entry-per-cycle table clear.
module cfg_store import cfg_store_pkg::*; #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int KEY_W       = KEY_W_DEF,
  parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
  parameter int LIST_DEPTH  = LIST_DEPTH_DEF
) (
  input logic        clk,
  input logic        rst_n,
  cfg_store_if.slave bus
);

  localparam int IDX_W  = $clog2(LIST_DEPTH) + 1;
  localparam int USED_W = $clog2(NUM_ENTRIES) + 1;
  localparam int ENT_W  = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int SLOT_W = (LIST_DEPTH > 1) ? $clog2(LIST_DEPTH) : 1;

  state_t                 state, state_nx;
  logic [ENT_W-1:0]       clr_ptr;
  logic [NUM_ENTRIES-1:0] valid;
  logic [KEY_W-1:0]       keys   [NUM_ENTRIES];
  logic [IDX_W-1:0]       counts [NUM_ENTRIES];
  logic [DATA_W-1:0]      lists  [NUM_ENTRIES][LIST_DEPTH];

  logic [NUM_ENTRIES-1:0] wr_match, rd_match;
  logic [ENT_W-1:0]       wr_ent, rd_ent, free_ent;
  logic                   free_any;
  logic                   wr_hit, rd_hit, rd_in, wr_fire, rd_fire, wr_bad, wr_ok;
  logic [SLOT_W-1:0]      wr_slot, rd_slot;
  logic [USED_W-1:0]      used;

  cfg_store_match #(
    .KEY_W       (KEY_W),
    .NUM_ENTRIES (NUM_ENTRIES),
    .ENT_W       (ENT_W)
  ) u_match (
    .valid    (valid),
    .keys     (keys),
    .wr_key   (bus.wr_key),
    .rd_key   (bus.rd_key),
    .wr_match (wr_match),
    .wr_ent   (wr_ent),
    .rd_match (rd_match),
    .rd_ent   (rd_ent),
    .free_any (free_any),
    .free_ent (free_ent)
  );

  assign wr_hit  = |wr_match;
  assign rd_hit  = |rd_match;
  assign wr_slot = bus.wr_idx[SLOT_W-1:0];
  assign rd_slot = bus.rd_idx[SLOT_W-1:0];
  assign rd_in   = rd_hit && (bus.rd_idx < counts[rd_ent]);
  assign wr_fire = bus.wr_valid && bus.wr_ready;
  assign rd_fire = bus.rd_valid && bus.rd_ready;
  assign wr_bad  = (bus.wr_idx >= IDX_W'(LIST_DEPTH)) || (!wr_hit && !free_any);
  assign wr_ok   = wr_fire && !wr_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.wr_ready = (state == IDLE);
    bus.rd_ready = (state == IDLE) && (!bus.rsp_valid || bus.rsp_ready);
    bus.clr_busy = (state == CLEAR);
    unique case (state)
      IDLE:    if (bus.clr_req) state_nx = CLEAR;
      CLEAR:   if (clr_ptr == ENT_W'(NUM_ENTRIES - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    used = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) used = used + USED_W'(valid[i]);
  end
  assign bus.used_cnt = used;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_ptr <= '0;
      valid   <= '0;
    end else if (state == CLEAR) begin
      valid[clr_ptr] <= 1'b0;
      clr_ptr        <= (clr_ptr == ENT_W'(NUM_ENTRIES - 1)) ? '0 : clr_ptr + 1'b1;
    end else if (wr_ok && !wr_hit) begin
      valid[free_ent] <= 1'b1;
    end
  end

  // A freshly allocated entry zeroes its whole list so slots below count that
  // were never written read back as 0; counts only grow until the entry dies.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_hit) begin
        lists[wr_ent][wr_slot] <= bus.wr_data;
        if (bus.wr_idx >= counts[wr_ent]) counts[wr_ent] <= bus.wr_idx + 1'b1;
      end else begin
        keys[free_ent]   <= bus.wr_key;
        counts[free_ent] <= bus.wr_idx + 1'b1;
        for (int unsigned j = 0; j < LIST_DEPTH; j++)
          lists[free_ent][j] <= (SLOT_W'(j) == wr_slot) ? bus.wr_data : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_hit   <= 1'b0;
      bus.rsp_count <= '0;
      bus.wr_err    <= 1'b0;
    end else begin
      bus.wr_err <= wr_fire && wr_bad;
      if (rd_fire) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_data  <= rd_in ? lists[rd_ent][rd_slot] : bus.rd_def;
        bus.rsp_hit   <= rd_in;
        bus.rsp_count <= rd_hit ? counts[rd_ent] : '0;
      end else if (bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cfg_store.sv
// Directed bench for cfg_store: a table-level reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_cfg_store;
  import cfg_store_pkg::*;

  localparam int DW = 32;
  localparam int KW = 16;
  localparam int NE = 16;
  localparam int LD = 8;
  localparam int IW = $clog2(LD) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  cfg_store_if #(.DATA_W(DW), .KEY_W(KW), .NUM_ENTRIES(NE), .LIST_DEPTH(LD)) bus ();

  cfg_store #(.DATA_W(DW), .KEY_W(KW), .NUM_ENTRIES(NE), .LIST_DEPTH(LD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  entry_t          mt [NE];
  logic [DW-1:0]   ml [NE][LD];
  int              busy_left;
  logic            e_rv, e_hit, e_err;
  logic [DW-1:0]   e_data;
  logic [IW-1:0]   e_cnt;

  function automatic int find_key(input logic [KW-1:0] k);
    for (int i = 0; i < NE; i++) if (mt[i].valid && mt[i].key == k) return i;
    return -1;
  endfunction

  function automatic int first_free();
    for (int i = 0; i < NE; i++) if (!mt[i].valid) return i;
    return -1;
  endfunction

  function automatic int n_used();
    int n = 0;
    for (int i = 0; i < NE; i++) if (mt[i].valid) n++;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int h, f, wi, ri;
    bit idle, wr_acc, rd_acc;
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) mt[i] = '0;
      busy_left = 0;
      e_rv = 1'b0; e_hit = 1'b0; e_err = 1'b0; e_data = '0; e_cnt = '0;
    end else begin
      idle   = (busy_left == 0);
      wr_acc = bus.wr_valid && idle;
      rd_acc = bus.rd_valid && idle && (!e_rv || bus.rsp_ready);
      if (rd_acc) begin
        h = find_key(bus.rd_key);
        ri = int'(bus.rd_idx);
        e_rv = 1'b1; e_hit = 1'b0; e_cnt = '0; e_data = bus.rd_def;
        if (h >= 0) begin
          e_cnt = mt[h].count;
          if (ri < int'(mt[h].count)) begin
            e_hit = 1'b1;
            e_data = ml[h][ri];
          end
        end
      end else if (e_rv && bus.rsp_ready) begin
        e_rv = 1'b0;
      end
      e_err = 1'b0;
      if (wr_acc) begin
        h = find_key(bus.wr_key);
        f = first_free();
        wi = int'(bus.wr_idx);
        if (wi >= LD || (h < 0 && f < 0)) begin
          e_err = 1'b1;
        end else if (h >= 0) begin
          ml[h][wi] = bus.wr_data;
          if (wi + 1 > int'(mt[h].count)) mt[h].count = CNT_W_DEF'(wi + 1);
        end else begin
          mt[f] = '{valid: 1'b1, key: bus.wr_key, count: CNT_W_DEF'(wi + 1)};
          for (int j = 0; j < LD; j++) ml[f][j] = '0;
          ml[f][wi] = bus.wr_data;
        end
      end
      if (!idle) begin
        mt[NE - busy_left].valid = 1'b0;
        busy_left--;
      end else if (bus.clr_req) begin
        busy_left = NE;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wr_ready", bus.wr_ready, busy_left == 0);
      chk("rd_ready", bus.rd_ready, busy_left == 0 && (!e_rv || bus.rsp_ready));
      chk("clr_busy", bus.clr_busy, busy_left != 0);
      chk("used_cnt", bus.used_cnt, n_used());
      chk("wr_err", bus.wr_err, e_err);
      chk("rsp_valid", bus.rsp_valid, e_rv);
      if (e_rv || !rst_n) begin
        chk("rsp_data", bus.rsp_data, e_data);
        chk("rsp_hit", bus.rsp_hit, e_hit);
        chk("rsp_count", bus.rsp_count, e_cnt);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit rd);
    int n = 0;
    while (!(rd ? bus.rd_ready : bus.wr_ready) && n < 64) begin
      step();
      n++;
    end
    chk(rd ? "rd_ready_wait" : "wr_ready_wait", rd ? bus.rd_ready : bus.wr_ready, 1'b1);
  endtask

  task automatic do_write(input logic [KW-1:0] k, input logic [IW-1:0] i,
                          input logic [DW-1:0] d, input logic exp_err);
    wait_ready(1'b0);
    bus.wr_valid = 1'b1; bus.wr_key = k; bus.wr_idx = i; bus.wr_data = d;
    step();
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("lit_wr_err", bus.wr_err, exp_err);
  endtask

  task automatic lookup(input logic [KW-1:0] k, input logic [IW-1:0] i, input logic [DW-1:0] def,
                        input logic [DW-1:0] x_data, input logic x_hit, input logic [IW-1:0] x_cnt,
                        input bit consume);
    wait_ready(1'b1);
    bus.rd_valid = 1'b1; bus.rd_key = k; bus.rd_idx = i; bus.rd_def = def;
    step();
    bus.rd_valid = 1'b0;
    @(negedge clk);
    chk("lit_rsp_valid", bus.rsp_valid, 1'b1);
    chk("lit_rsp_data", bus.rsp_data, x_data);
    chk("lit_rsp_hit", bus.rsp_hit, x_hit);
    chk("lit_rsp_count", bus.rsp_count, x_cnt);
    if (consume) begin
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_ready"}, bus.wr_ready, 1'b1);
    chk({tag, "_rd_ready"}, bus.rd_ready, 1'b1);
    chk({tag, "_clr_busy"}, bus.clr_busy, 1'b0);
    chk({tag, "_used"}, bus.used_cnt, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 0);
    chk({tag, "_rsp_hit"}, bus.rsp_hit, 1'b0);
    chk({tag, "_rsp_count"}, bus.rsp_count, 0);
    chk({tag, "_wr_err"}, bus.wr_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_valid = 1'b0; bus.wr_key = '0; bus.wr_idx = '0; bus.wr_data = '0;
    bus.rd_valid = 1'b0; bus.rd_key = '0; bus.rd_idx = '0; bus.rd_def = '0;
    bus.rsp_ready = 1'b0; bus.clr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk_reset_outputs("in_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("after_reset");

    // basic write / lookup, misses and out-of-count index
    do_write(16'h0101, 4'd0, 32'h5, 1'b0);
    lookup(16'h0101, 4'd0, 32'h99,   32'h5,    1'b1, 4'd1, 1'b1);
    lookup(16'h0202, 4'd0, 32'hDEAD, 32'hDEAD, 1'b0, 4'd0, 1'b1);
    lookup(16'h0101, 4'd3, 32'hBEEF, 32'hBEEF, 1'b0, 4'd1, 1'b1);

    // gap slots below count read as zero
    do_write(16'h0101, 4'd2, 32'hA, 1'b0);
    lookup(16'h0101, 4'd1, 32'h55, 32'h0, 1'b1, 4'd3, 1'b1);
    lookup(16'h0101, 4'd2, 32'h55, 32'hA, 1'b1, 4'd3, 1'b1);

    // same-cycle write and lookup: lookup sees the old value
    bus.wr_valid = 1'b1; bus.wr_key = 16'h0101; bus.wr_idx = 4'd0; bus.wr_data = 32'h7;
    bus.rd_valid = 1'b1; bus.rd_key = 16'h0101; bus.rd_idx = 4'd0; bus.rd_def = 32'h0;
    step();
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
    @(negedge clk);
    chk("same_cycle_data", bus.rsp_data, 32'h5);
    chk("same_cycle_wr_err", bus.wr_err, 1'b0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    lookup(16'h0101, 4'd0, 32'h0, 32'h7, 1'b1, 4'd3, 1'b1);

    // index out of range
    do_write(16'h0101, 4'd8,  32'h1, 1'b1);
    do_write(16'h0101, 4'd15, 32'h1, 1'b1);
    chk("used_one", bus.used_cnt, 1);

    // fill the table, then overflow
    for (int i = 0; i < NE - 1; i++)
      do_write(KW'(16'h1000 + i), 4'd0, DW'(32'h100 + i), 1'b0);
    chk("used_full", bus.used_cnt, 16);
    do_write(16'h2000, 4'd0, 32'h1, 1'b1);
    chk("used_after_overflow", bus.used_cnt, 16);
    do_write(16'h1003, 4'd1, 32'h55, 1'b0);
    lookup(16'h1003, 4'd1, 32'h0, 32'h55, 1'b1, 4'd2, 1'b1);

    // clear with a response held pending
    lookup(16'h1005, 4'd0, 32'h0, 32'h105, 1'b1, 4'd1, 1'b0);
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    for (int c = 0; c < NE; c++) begin
      @(negedge clk);
      chk("clr_busy_lit", bus.clr_busy, 1'b1);
      chk("clr_wr_ready", bus.wr_ready, 1'b0);
      chk("clr_rd_ready", bus.rd_ready, 1'b0);
      chk("clr_rsp_held", bus.rsp_valid, 1'b1);
      chk("clr_rsp_data", bus.rsp_data, 32'h105);
      chk("clr_used", bus.used_cnt, NE - c);
      if (c == 3) begin
        bus.clr_req = 1'b1;
        bus.wr_valid = 1'b1; bus.wr_key = 16'h3000; bus.wr_idx = 4'd0; bus.wr_data = 32'h3;
        bus.rd_valid = 1'b1; bus.rd_key = 16'h1000; bus.rd_idx = 4'd0;
      end
      step();
      bus.clr_req = 1'b0; bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
    end
    @(negedge clk);
    chk("post_clr_busy", bus.clr_busy, 1'b0);
    chk("post_clr_used", bus.used_cnt, 0);
    chk("post_clr_rsp_held", bus.rsp_valid, 1'b1);
    chk("post_clr_wr_ready", bus.wr_ready, 1'b1);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    lookup(16'h1005, 4'd0, 32'h77, 32'h77, 1'b0, 4'd0, 1'b1);
    lookup(16'h0101, 4'd0, 32'h78, 32'h78, 1'b0, 4'd0, 1'b1);
    lookup(16'h3000, 4'd0, 32'h79, 32'h79, 1'b0, 4'd0, 1'b1);

    // reset in the middle of a clear with a pending response
    do_write(16'h4000, 4'd0, 32'hAA, 1'b0);
    do_write(16'h4001, 4'd1, 32'hBB, 1'b0);
    lookup(16'h4001, 4'd1, 32'h0, 32'hBB, 1'b1, 4'd2, 1'b0);
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid_clr_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("post_rst_clr_busy", bus.clr_busy, 1'b0);
    end
    lookup(16'h4000, 4'd0, 32'h1, 32'h1, 1'b0, 4'd0, 1'b1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cfg_store.md
CFG_STORE -- requirements
Module: cfg_store

Interface
REQ-001 Parameter DATA_W, default 32: width of one stored value.
REQ-002 Parameter KEY_W, default 16: width of the object/property key.
REQ-003 Parameter NUM_ENTRIES, default 16: number of keys the table holds.
REQ-004 Parameter LIST_DEPTH, default 8: maximum list length per key.
REQ-005 Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when high with wr_valid.
- wr_key  in  KEY_W  key written.
- wr_idx  in  clog2(LIST_DEPTH)+1  list index written.
- wr_data  in  DATA_W  value written.
- wr_err  out  1  one-cycle pulse: accepted write was dropped.
- rd_valid  in  1  lookup request.
- rd_ready  out  1  lookup accepted when high with rd_valid.
- rd_key  in  KEY_W  key looked up.
- rd_idx  in  clog2(LIST_DEPTH)+1  list index looked up.
- rd_def  in  DATA_W  default value returned on miss.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_data  out  DATA_W  looked-up value, or rd_def on miss.
- rsp_hit  out  1  key present and rd_idx < count.
- rsp_count  out  clog2(LIST_DEPTH)+1  list length of key; 0 if key absent.
- clr_req  in  1  pulse: invalidate whole table.
- clr_busy  out  1  clear sequence in progress.
- used_cnt  out  clog2(NUM_ENTRIES)+1  number of valid entries.

Function
REQ-006 Each entry SHALL hold valid, key, count (0..LIST_DEPTH) and LIST_DEPTH values.
REQ-007 FSM states IDLE and CLEAR; IDLE->CLEAR on clr_req; CLEAR->IDLE after the last entry is cleared; clr_req in CLEAR is ignored.
REQ-008 CLEAR SHALL invalidate one entry per cycle, lowest index first, taking exactly NUM_ENTRIES cycles; used_cnt = 0 on exit.
REQ-009 wr_ready SHALL be high only in IDLE.
REQ-010 Write on key hit: list[wr_idx] = wr_data; count = max(count, wr_idx+1).
REQ-011 Write on key miss: allocate lowest-indexed invalid entry, set key, list[wr_idx] = wr_data, count = wr_idx+1, used_cnt increments.
REQ-012 Write with wr_idx >= LIST_DEPTH, or miss with table full: table unchanged, wr_err pulses the next cycle.
REQ-013 Unwritten list slots below count SHALL read 0.
REQ-014 rd_ready = IDLE and (not rsp_valid or rsp_ready).
REQ-015 An accepted lookup SHALL raise rsp_valid the next cycle; rsp_* hold stable until rsp_valid and rsp_ready.
REQ-016 Write and lookup accepted in the same cycle: lookup SHALL see the table before the write.
REQ-017 A response pending at clr_req SHALL stay held until consumed; no lookup is accepted during CLEAR.

Reset
REQ-018 During and after reset: all entries invalid, state IDLE, used_cnt = 0, rsp_valid = 0, rsp_data = 0, rsp_hit = 0, rsp_count = 0, wr_err = 0, clr_busy = 0, wr_ready = 1, rd_ready = 1.
REQ-019 Reset asserted mid-CLEAR or with a pending response SHALL abandon it; nothing is delivered after release.

Structure
REQ-020 Package cfg_store_pkg SHALL hold the parameter defaults, the entry struct typedef and the state enum.
REQ-021 Sub-module cfg_store_match SHALL compute key-match one-hot, hit index and lowest free index combinationally.

Verification
REQ-022 Write key 0x0101 idx 0 data 0x5; lookup key 0x0101 idx 0, def 0x99 -> next cycle rsp_valid, data 0x5, hit 1, count 1.
REQ-023 Lookup absent key 0x0202, def 0xDEAD -> data 0xDEAD, hit 0, count 0; lookup 0x0101 idx 3 -> data rd_def, hit 0, count 1.
REQ-024 Write 17 distinct keys (NUM_ENTRIES=16) -> 17th write gives wr_err pulse, used_cnt = 16; write idx 8 to an existing key -> wr_err.
REQ-025 Same-cycle write 0x0101 idx 0 data 0x7 and lookup of it -> response 0x5; following lookup -> 0x7.
REQ-026 clr_req with rsp_ready low -> clr_busy high 16 cycles, ready outputs low, response held; then used_cnt 0, lookups miss.
REQ-027 rst_n low for one cycle mid-CLEAR -> all outputs at reset values, state IDLE, no response delivered.
